// File: rtl/job_ab_sequencer.sv
// Time-shares one downstream A/B handshake unit among NREQ requesters: arbitrates, pulses A,B,A, checks Q edges.
// Define JOB_AB_PRIO_EN for fixed lowest-index priority instead of round-robin.
module job_ab_sequencer #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  done,
    output logic             err,
    output logic [2:0]       err_id,
    output logic             a_out,
    output logic             b_out,
    input  logic             q_in,
    output logic             busy,
    output logic [CNT_W-1:0] job_cnt
);

    localparam int unsigned ID_W     = 3;
    localparam int unsigned TMR_W    = 8;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PULSE_A  = 3'd1,
        PULSE_B  = 3'd2,
        WAIT_Q   = 3'd3,
        RELEASE  = 3'd4,
        WAIT_CLR = 3'd5,
        DONE_S   = 3'd6,
        ERR_S    = 3'd7
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [ID_W-1:0]   win_id;

    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              err_q, err_d;
    logic [2:0]        err_id_q, err_id_d;
    logic              a_q, a_d;
    logic              b_q, b_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  job_cnt_q, job_cnt_d;
    logic [NREQ-1:0]   onehot;

`ifdef JOB_AB_PRIO_EN
    // Lowest asserted index wins.
    always_comb begin : arbiter
        win_id = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) win_id = ID_W'(i);
        end
    end
`else
    logic [ID_W-1:0] rr_q, rr_d;
    logic            hi_found;
    logic [ID_W-1:0] hi_id, lo_id;

    // First requester at or above the pointer, else wrap to the lowest one.
    always_comb begin : arbiter
        hi_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_id = ID_W'(i);
                if (ID_W'(i) >= rr_q) begin
                    hi_found = 1'b1;
                    hi_id    = ID_W'(i);
                end
            end
        end
        win_id = hi_found ? hi_id : lo_id;
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            id_q    <= '0;
            timer_q <= '0;
`ifndef JOB_AB_PRIO_EN
            rr_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            timer_q <= timer_d;
`ifndef JOB_AB_PRIO_EN
            rr_q    <= rr_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin : next_state
        state_d = state_q;
        id_d    = id_q;
        timer_d = timer_q;
`ifndef JOB_AB_PRIO_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    id_d    = win_id;
`ifndef JOB_AB_PRIO_EN
                    rr_d    = (win_id == ID_W'(NREQ - 1)) ? '0 : win_id + ID_W'(1);
`endif
                    state_d = PULSE_A;
                end
            end
            PULSE_A: state_d = PULSE_B;
            PULSE_B: begin
                timer_d = '0;
                state_d = WAIT_Q;
            end
            WAIT_Q: begin
                if (q_in)                     state_d = RELEASE;
                else if (timer_q == TMR_LAST) state_d = ERR_S;
                else                          timer_d = timer_q + TMR_W'(1);
            end
            RELEASE: begin
                timer_d = '0;
                state_d = WAIT_CLR;
            end
            WAIT_CLR: begin
                if (!q_in)                    state_d = DONE_S;
                else if (timer_q == TMR_LAST) state_d = ERR_S;
                else                          timer_d = timer_q + TMR_W'(1);
            end
            DONE_S:  state_d = IDLE;
            ERR_S:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the next state so every port comes straight from a flop.
    always_comb begin : output_decode
        onehot    = NREQ'(1) << id_d;
        gnt_d     = '0;
        done_d    = '0;
        err_d     = 1'b0;
        err_id_d  = '0;
        a_d       = 1'b0;
        b_d       = 1'b0;
        busy_d    = 1'b0;
        job_cnt_d = job_cnt_q;
        case (state_d)
            PULSE_A: a_d = 1'b1;
            PULSE_B: b_d = 1'b1;
            RELEASE: a_d = 1'b1;
            DONE_S: begin
                done_d    = onehot;
                job_cnt_d = job_cnt_q + CNT_W'(1);
            end
            ERR_S: begin
                err_d    = 1'b1;
                err_id_d = id_d;
            end
            default: ;
        endcase
        if (state_d != IDLE) begin
            gnt_d  = onehot;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            err_id_q  <= '0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            busy_q    <= 1'b0;
            job_cnt_q <= '0;
        end else begin
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_id_q  <= err_id_d;
            a_q       <= a_d;
            b_q       <= b_d;
            busy_q    <= busy_d;
            job_cnt_q <= job_cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign err     = err_q;
    assign err_id  = err_id_q;
    assign a_out   = a_q;
    assign b_out   = b_q;
    assign busy    = busy_q;
    assign job_cnt = job_cnt_q;

endmodule

// File: tb/tb_job_ab_sequencer.sv
// Directed bench for job_ab_sequencer with a behavioural downstream A/B unit and a completion scoreboard.
module tb_job_ab_sequencer;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned TIMEOUT = 15;
    localparam int unsigned CNT_W   = 2;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b0;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  gnt;
    logic [NREQ-1:0]  done;
    logic             err;
    logic [2:0]       err_id;
    logic             a_out;
    logic             b_out;
    logic             q_in;
    logic             busy;
    logic [CNT_W-1:0] job_cnt;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [NREQ-1:0]  done_v;
        logic             err;
        logic [2:0]       id;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             mon_e;
    int               rr_m;
    logic [CNT_W-1:0] cnt_m;
    int               ds_mode;   // 0 ideal, 1 Q never rises, 2 Q never falls
    logic             ds_clr;
    logic [1:0]       ds_st;

    job_ab_sequencer #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .gnt     (gnt),
        .done    (done),
        .err     (err),
        .err_id  (err_id),
        .a_out   (a_out),
        .b_out   (b_out),
        .q_in    (q_in),
        .busy    (busy),
        .job_cnt (job_cnt)
    );

    always #5 clk = ~clk;

    // Downstream unit: A S0->S1, B S1->S2 (Q=1), A S2->S0.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) ds_st <= 2'd0;
        else if (ds_clr) ds_st <= 2'd0;
        else begin
            case (ds_st)
                2'd0: if (a_out) ds_st <= 2'd1;
                2'd1: if (b_out) ds_st <= 2'd2;
                2'd2: if (a_out && ds_mode != 2) ds_st <= 2'd0;
                default: ds_st <= 2'd0;
            endcase
        end
    end
    assign q_in = (ds_st == 2'd2) && (ds_mode != 1);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int rr);
        int w;
        w = -1;
`ifdef JOB_AB_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) if (r[i]) w = i + 0 * rr;
`else
        for (int k = NREQ - 1; k >= 0; k--) if (r[(rr + k) % NREQ]) w = (rr + k) % NREQ;
`endif
        return w;
    endfunction

    // Scoreboard: every done/err pulse must match the next expected completion.
    always @(negedge clk) begin
        if (reset_n) begin
            check("ab_excl", 32'(a_out & b_out), 32'(0));
            if (done !== '0 || err !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected", 32'({done, err}), 32'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_done", 32'(done), 32'(mon_e.done_v));
                    check("sb_err", 32'(err), 32'(mon_e.err));
                    if (mon_e.err) check("sb_err_id", 32'(err_id), 32'(mon_e.id));
                    check("sb_cnt", 32'(job_cnt), 32'(mon_e.cnt));
                end
            end
        end
    end

    // One job: predict winner/result, drive req, trace the handshake, check latency and the IDLE cycle.
    task automatic do_job(input logic [NREQ-1:0] r, input int mode, input int drop_at,
                          input bit hold, input int exp_lat);
        int w;
        int n;
        logic [NREQ-1:0] oh;
        exp_t e;
        w = pick(r, rr_m);
`ifndef JOB_AB_PRIO_EN
        rr_m = (w + 1) % NREQ;
`endif
        oh       = NREQ'(1) << w;
        e.err    = (mode != 0);
        e.id     = 3'(w);
        e.done_v = e.err ? '0 : oh;
        if (!e.err) cnt_m = cnt_m + CNT_W'(1);
        e.cnt    = cnt_m;
        exp_q.push_back(e);
        ds_mode = mode;
        req     = r;
        n       = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == drop_at) req = '0;
            check("gnt", 32'(gnt), 32'(oh));
            check("busy", 32'(busy), 32'(1));
            if (mode == 0) begin
                check("a_out", 32'(a_out), 32'(n == 1 || n == 4));
                check("b_out", 32'(b_out), 32'(n == 2));
            end
        end while (done == '0 && err == 1'b0 && n < exp_lat + 5);
        if (!hold) req = '0;
        check("latency", 32'(n), 32'(exp_lat));
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'(0));
        check("idle_gnt", 32'(gnt), 32'(0));
        check("idle_cnt", 32'(job_cnt), 32'(cnt_m));
        if (mode != 0) begin
            ds_clr = 1'b1;
            @(negedge clk);
            ds_clr = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(0));
        check({tag, "_err"}, 32'(err), 32'(0));
        check({tag, "_err_id"}, 32'(err_id), 32'(0));
        check({tag, "_a"}, 32'(a_out), 32'(0));
        check({tag, "_b"}, 32'(b_out), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_cnt"}, 32'(job_cnt), 32'(0));
    endtask

    initial begin
        req     = '0;
        ds_mode = 0;
        ds_clr  = 1'b0;
        rr_m    = 0;
        cnt_m   = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Single job on requester 0
        do_job(4'b0001, 0, 0, 1'b0, 6);

        // Fresh reset, then all requesters held: grants 7 cycles apart, counter wraps 1,2,3,0,1
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rr_m    = 0;
        cnt_m   = '0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) do_job(4'b1111, 0, 0, i < 4, 6);

        // Q never rises: err 15 cycles into WAIT_Q
        do_job(4'b0100, 1, 0, 1'b0, 18);

        // Q never falls: err 15 cycles into WAIT_CLR
        do_job(4'b1000, 2, 0, 1'b0, 20);

        // req dropped during PULSE_B still completes
        do_job(4'b0001, 0, 2, 1'b0, 6);

        // Mixed request patterns
        for (int i = 0; i < 6; i++) do_job(NREQ'($urandom_range(1, 15)), 0, 0, 1'b0, 6);

        // Asynchronous reset in WAIT_Q, then a fresh job from pointer 0
        ds_mode = 1;
        req     = 4'b0001;
        repeat (5) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'(1));
        #2 reset_n = 1'b0;
        #1 check_all_zero("async_rst");
        req   = '0;
        rr_m  = 0;
        cnt_m = '0;
        @(negedge clk);
        reset_n = 1'b1;
        ds_mode = 0;
        @(negedge clk);
        check_all_zero("post_rst");
        do_job(4'b0010, 0, 0, 1'b0, 6);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
